// File: rtl/gpio_link_arbiter.sv
// Two-requester round-robin arbiter that hands one 128-bit message at a time to the gpio_protocol link.
// Optional SEND watchdog enabled by defining GPIO_LINK_ARB_TIMEOUT_EN.
module gpio_link_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic [127:0] msg0,
  output logic         ack0,
  input  logic         req1,
  input  logic [127:0] msg1,
  output logic         ack1,
  output logic         link_ready,
  output logic [127:0] link_msg,
  input  logic         link_done,
  output logic         busy,
  output logic         owner,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } state_t;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("gpio_link_arbiter: TIMEOUT must be within 2..65535");
  end

  state_t       state, state_nx;
  logic         ready_nx;
  logic [127:0] msg_nx;
  logic         owner_nx;
  logic         last_q, last_nx;
  logic         ack0_nx, ack1_nx;

  // Requester 1 wins when alone, or on contention when requester 0 was served last.
  logic pick_one;
  assign pick_one = req1 & (~req0 | ~last_q);

  assign busy = (state != IDLE);

`ifdef GPIO_LINK_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_nx;
  logic        err_nx;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    ready_nx = link_ready;
    msg_nx   = link_msg;
    owner_nx = owner;
    last_nx  = last_q;
    ack0_nx  = 1'b0;
    ack1_nx  = 1'b0;
`ifdef GPIO_LINK_ARB_TIMEOUT_EN
    cnt_nx   = cnt_q;
    err_nx   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx = SEND;
          ready_nx = 1'b1;
          owner_nx = pick_one;
          msg_nx   = pick_one ? msg1 : msg0;
`ifdef GPIO_LINK_ARB_TIMEOUT_EN
          cnt_nx   = 16'd0;
`endif
        end
      end
      SEND: begin
        if (link_done) begin
          state_nx = DONE;
          ready_nx = 1'b0;
          ack0_nx  = ~owner;
          ack1_nx  = owner;
        end
`ifdef GPIO_LINK_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // Abandon the stalled transfer but still release the requester.
          state_nx = IDLE;
          ready_nx = 1'b0;
          err_nx   = 1'b1;
          ack0_nx  = ~owner;
          ack1_nx  = owner;
          last_nx  = owner;
        end else begin
          cnt_nx = cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        if (!link_done) begin
          state_nx = IDLE;
          last_nx  = owner;
        end
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      link_ready <= 1'b0;
      link_msg   <= '0;
      owner      <= 1'b0;
      last_q     <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state      <= state_nx;
      link_ready <= ready_nx;
      link_msg   <= msg_nx;
      owner      <= owner_nx;
      last_q     <= last_nx;
      ack0       <= ack0_nx;
      ack1       <= ack1_nx;
    end
  end

`ifdef GPIO_LINK_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
      err   <= 1'b0;
    end else begin
      cnt_q <= cnt_nx;
      err   <= err_nx;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_link_arbiter.sv
// Randomized and directed bench for gpio_link_arbiter, checked every cycle against a transaction-level model.
module tb_gpio_link_arbiter;

  localparam int TO = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [127:0] msg0 = '0, msg1 = '0;
  logic         ack0, ack1;
  logic         link_ready;
  logic [127:0] link_msg;
  logic         link_done = 1'b0;
  logic         busy, owner, err;

  int tests = 0;
  int fails = 0;

  gpio_link_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .msg0(msg0), .ack0(ack0),
    .req1(req1), .msg1(msg1), .ack1(ack1),
    .link_ready(link_ready), .link_msg(link_msg), .link_done(link_done),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 waiting, 1 message offered, 2 waiting for done to drop.
  int           m_phase;
  int           m_cnt;
  logic         m_ready, m_owner, m_last, m_ack0, m_ack1, m_err;
  logic [127:0] m_msg;
  logic         m_pick;
  assign m_pick = (req0 && req1) ? !m_last : req1;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_cnt <= 0; m_ready <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
      m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_err <= 1'b0; m_msg <= '0;
    end else begin
      m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_err <= 1'b0;
      if (m_phase == 0) begin
        if (req0 || req1) begin
          m_phase <= 1; m_ready <= 1'b1; m_owner <= m_pick; m_cnt <= 0;
          m_msg <= m_pick ? msg1 : msg0;
        end
      end else if (m_phase == 1) begin
        if (link_done) begin
          m_phase <= 2; m_ready <= 1'b0;
          m_ack0 <= (m_owner == 1'b0); m_ack1 <= (m_owner == 1'b1);
        end
`ifdef GPIO_LINK_ARB_TIMEOUT_EN
        else if (m_cnt == TO - 1) begin
          m_phase <= 0; m_ready <= 1'b0; m_err <= 1'b1; m_last <= m_owner;
          m_ack0 <= (m_owner == 1'b0); m_ack1 <= (m_owner == 1'b1);
        end
`endif
        else m_cnt <= m_cnt + 1;
      end else begin
        if (!link_done) begin
          m_phase <= 0; m_last <= m_owner;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("cmp_link_ready", link_ready, m_ready);
      check("cmp_link_msg", link_msg, m_msg);
      check("cmp_owner", owner, m_owner);
      check("cmp_ack0", ack0, m_ack0);
      check("cmp_ack1", ack1, m_ack1);
      check("cmp_err", err, m_err);
      check("cmp_busy", busy, m_phase != 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; link_done = 1'b0;
    #1;
    check("rst_link_ready", link_ready, 0);
    check("rst_link_msg", link_msg, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_acks", {ack0, ack1, err}, 0);
    step(1);
    reset = 1'b1;
  endtask

  task automatic wait_ready(input int max);
    for (int i = 0; i < max; i++) begin
      if (link_ready) break;
      step(1);
    end
    check("wait_ready", link_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ma, mb;
    step(1);
    do_reset();

    // Single request, done 5 cycles after grant.
    ma = {32'h156, 32'd3145, 32'd29455, 32'd939415};
    req0 = 1'b1; msg0 = ma;
    step(1);
    check("single_ready", link_ready, 1);
    check("single_msg", link_msg, {32'h0000_0156, 32'h0000_0c49, 32'h0000_730f, 32'h000e_5597});
    check("single_owner", owner, 0);
    req0 = 1'b0; msg0 = '1;
    step(4);
    check("single_no_ack", {ack0, ack1}, 0);
    link_done = 1'b1;
    step(1);
    check("single_ack0", {ack0, ack1}, 2'b10);
    check("single_ready_drop", link_ready, 0);
    check("single_msg_stable", link_msg, ma);
    step(1);
    check("single_ack_once", {ack0, ack1}, 0);
    link_done = 1'b0;
    step(1);
    check("single_idle", busy, 0);

    // Contention: grants 0,1,0.
    do_reset();
    ma = {4{32'hA5A5_0000}}; mb = {4{32'h0000_5A5A}};
    req0 = 1'b1; req1 = 1'b1; msg0 = ma; msg1 = mb;
    for (int i = 0; i < 3; i++) begin
      wait_ready(6);
      check("cont_owner", owner, i % 2);
      check("cont_msg", link_msg, (i % 2) ? mb : ma);
      step(2);
      check("cont_no_early_ack", {ack0, ack1}, 0);
      link_done = 1'b1;
      step(1);
      check("cont_ack", {ack0, ack1}, (i % 2) ? 2'b01 : 2'b10);
      link_done = 1'b0;
      step(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    step(2);

    // Done held high in DONE: no second grant until it falls.
    do_reset();
    req1 = 1'b1; msg1 = mb;
    step(1);
    check("hold_owner1", owner, 1);
    req1 = 1'b0; req0 = 1'b1; msg0 = ma; link_done = 1'b1;
    step(1);
    check("hold_ack1", ack1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("hold_busy", busy, 1);
      check("hold_no_grant", {link_ready, owner}, 2'b01);
    end
    link_done = 1'b0;
    step(1);
    check("hold_idle", busy, 0);
    step(1);
    check("hold_next_owner0", {link_ready, owner}, 2'b10);
    req0 = 1'b0; link_done = 1'b1;
    step(1);
    link_done = 1'b0;
    step(2);

`ifdef GPIO_LINK_ARB_TIMEOUT_EN
    // Timeout: done never rises.
    do_reset();
    req0 = 1'b1; msg0 = ma;
    step(1);
    req0 = 1'b0;
    step(7);
    check("to_still_ready", link_ready, 1);
    step(1);
    check("to_ready_drop", link_ready, 0);
    check("to_err_ack0", {err, ack0, ack1}, 3'b110);
    check("to_idle", busy, 0);
    step(1);
    check("to_pulse_end", {err, ack0, ack1}, 0);
`endif

    // Reset mid-SEND discards the transfer and restores requester 0 priority.
    do_reset();
    req0 = 1'b1; msg0 = ma;
    step(1);
    req0 = 1'b0; link_done = 1'b1;
    step(1);
    link_done = 1'b0;
    step(1);
    req1 = 1'b1; msg1 = mb;
    step(1);
    check("rms_owner1", owner, 1);
    step(2);
    reset = 1'b0;
    #1;
    check("rms_ready_async", link_ready, 0);
    check("rms_busy_async", busy, 0);
    step(1);
    check("rms_no_ack", {ack0, ack1}, 0);
    reset = 1'b1; req0 = 1'b1;
    step(1);
    check("rms_owner0", {link_ready, owner}, 2'b10);
    check("rms_msg0", link_msg, ma);
    req0 = 1'b0; req1 = 1'b0; link_done = 1'b1;
    step(1);
    link_done = 1'b0;
    step(2);

    // Stray done in IDLE, then req1 dropped mid-SEND.
    do_reset();
    link_done = 1'b1;
    step(2);
    check("stray_idle", {busy, link_ready, ack0, ack1}, 0);
    link_done = 1'b0;
    step(1);
    req1 = 1'b1; msg1 = mb;
    step(1);
    req1 = 1'b0;
    step(2);
    check("drop_still_ready", {link_ready, owner}, 2'b11);
    link_done = 1'b1;
    step(1);
    check("drop_ack1", {ack0, ack1}, 2'b01);
    link_done = 1'b0;
    step(2);

    // Randomized traffic checked by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req0 = ($urandom_range(0, 2) == 0);
      req1 = ($urandom_range(0, 2) == 0);
      msg0 = {$urandom, $urandom, $urandom, $urandom};
      msg1 = {$urandom, $urandom, $urandom, $urandom};
      link_done = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) != 0);
      step(1);
    end
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; link_done = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
